// File: rtl/ddr2_pkg.sv
// Shared DDR2 command encodings, transaction record and error codes
// used by the bank tracker, its FIFO and the bus monitor.
package ddr2_pkg;

  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned BA_W      = 2;
  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned COL_W     = 10;
  localparam int unsigned AP_BIT    = 10;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [1:0] {
    TXN_ACT = 2'd0,
    TXN_RD  = 2'd1,
    TXN_WR  = 2'd2,
    TXN_PRE = 2'd3
  } txn_cmd_e;

  typedef struct packed {
    txn_cmd_e            cmd;
    logic [BA_W-1:0]     bank;
    logic [ADDR_W-1:0]   row;
    logic [COL_W-1:0]    col;
    logic                ap;
  } ddr2_txn_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_CLOSED   = 3'd1,
    ERR_ACT_OPEN = 3'd2,
    ERR_TRCD     = 3'd3,
    ERR_OVF      = 3'd4
  } err_code_e;

endpackage

// File: rtl/ddr2_txn_fifo.sv
// First-word fall-through FIFO of decoded transactions with a registered head
// and registered valid/full flags; push while full succeeds only with a pop.
module ddr2_txn_fifo
  import ddr2_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  ddr2_txn_t din,
  input  logic      pop,
  output logic      valid,
  output logic      full,
  output ddr2_txn_t head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ddr2_txn_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;
  ddr2_txn_t        head_next;

  // The next head is the entry being written when it lands on the new read slot.
  always_comb begin
    do_pop     = pop && valid;
    do_push    = push && (!full || do_pop);
    rd_next    = rd_ptr + PTR_W'(do_pop);
    count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
    head_next  = (do_push && (wr_ptr == rd_next)) ? din : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(do_push);
      rd_ptr <= rd_next;
      count  <= count_next;
      valid  <= (count_next != '0);
      full   <= (count_next == CNT_W'(DEPTH));
      if (count_next != '0) head <= head_next;
    end
  end

endmodule

// File: rtl/ddr2_bank_tracker.sv
// Passive DDR2 command-bus decoder: tracks open rows and tRCD per bank, flags
// protocol errors and queues decoded transactions for the scoreboard.
module ddr2_bank_tracker
  import ddr2_pkg::*;
#(
  parameter int unsigned TRCD       = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              ck,
  input  logic              reset,
  input  logic              cke,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BA_W-1:0]   ba,
  input  logic              cs_n,
  input  logic              ras_n,
  input  logic              cas_n,
  input  logic              we_n,
  output logic              txn_valid,
  input  logic              txn_ready,
  output logic [1:0]        txn_cmd,
  output logic [BA_W-1:0]   txn_bank,
  output logic [ADDR_W-1:0] txn_row,
  output logic [COL_W-1:0]  txn_col,
  output logic              txn_ap,
  output logic              err_valid,
  output logic [2:0]        err_code,
  output logic              overflow,
  output logic [NUM_BANKS-1:0] open_banks
);

  localparam int unsigned     CNT_W    = $clog2(TRCD + 1);
  localparam logic [CNT_W-1:0] TRCD_CNT = CNT_W'(TRCD);

  logic                 cke_prev;
  logic [ADDR_W-1:0]    row_q [NUM_BANKS];
  logic [CNT_W-1:0]     cnt_q [NUM_BANKS];
  logic [NUM_BANKS-1:0] open_d;
  logic [3:0]           cmd_bits;
  logic                 dec_en;
  logic                 is_act;
  logic                 push;
  logic                 drop;
  logic                 fifo_full;
  ddr2_txn_t            push_txn;
  ddr2_txn_t            head;
  err_code_e            prot_err;

  // Command decode, open-table next state and protocol checks.
  always_comb begin
    cmd_bits = {cs_n, ras_n, cas_n, we_n};
    dec_en   = cke && cke_prev;
    is_act   = dec_en && (cmd_bits == CMD_ACT);
    push     = 1'b0;
    push_txn = '0;
    prot_err = ERR_NONE;
    open_d   = open_banks;
    if (is_act) begin
      push          = 1'b1;
      push_txn.cmd  = TXN_ACT;
      push_txn.bank = ba;
      push_txn.row  = addr;
      if (open_banks[ba]) prot_err = ERR_ACT_OPEN;
      open_d[ba] = 1'b1;
    end else if (dec_en && ((cmd_bits == CMD_RD) || (cmd_bits == CMD_WR))) begin
      if (!open_banks[ba]) begin
        prot_err = ERR_CLOSED;
      end else begin
        push          = 1'b1;
        push_txn.cmd  = (cmd_bits == CMD_RD) ? TXN_RD : TXN_WR;
        push_txn.bank = ba;
        push_txn.row  = row_q[ba];
        push_txn.col  = addr[COL_W-1:0];
        push_txn.ap   = addr[AP_BIT];
        if (cnt_q[ba] < TRCD_CNT) prot_err = ERR_TRCD;
        if (addr[AP_BIT]) open_d[ba] = 1'b0;
      end
    end else if (dec_en && (cmd_bits == CMD_PRE)) begin
      push         = 1'b1;
      push_txn.cmd = TXN_PRE;
      if (addr[AP_BIT]) begin
        push_txn.ap = 1'b1;
        open_d      = '0;
      end else begin
        push_txn.bank = ba;
        open_d[ba]    = 1'b0;
      end
    end
    drop = push && fifo_full && !(txn_valid && txn_ready);
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      cke_prev   <= 1'b0;
      open_banks <= '0;
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      overflow   <= 1'b0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        row_q[b] <= '0;
        cnt_q[b] <= TRCD_CNT;
      end
    end else begin
      cke_prev   <= cke;
      open_banks <= open_d;
      err_valid  <= (prot_err != ERR_NONE) || drop;
      err_code   <= (prot_err != ERR_NONE) ? prot_err : (drop ? ERR_OVF : ERR_NONE);
      overflow   <= overflow || drop;
      // tRCD counters run every edge, including while cke is low.
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (is_act && (ba == BA_W'(b))) begin
          row_q[b] <= addr;
          cnt_q[b] <= CNT_W'(1);
        end else if (cnt_q[b] < TRCD_CNT) begin
          cnt_q[b] <= cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  ddr2_txn_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (ck),
    .rst  (reset),
    .push (push),
    .din  (push_txn),
    .pop  (txn_ready),
    .valid(txn_valid),
    .full (fifo_full),
    .head (head)
  );

  assign txn_cmd  = head.cmd;
  assign txn_bank = head.bank;
  assign txn_row  = head.row;
  assign txn_col  = head.col;
  assign txn_ap   = head.ap;

endmodule

// File: doc/ddr2_bank_tracker.md
Name: ddr2_bank_tracker

Overview:
- Passive, synthesizable stage that decodes the DDR2 controller→DRAM command bus in lockstep with the bus monitor.
- Maintains per-bank open-row state and a per-bank tRCD timer.
- Flags protocol violations and emits decoded transaction records (command, bank, row, column) into a FIFO with a valid/ready output for the scoreboard.
- Transaction source for downstream checking; never drives the DRAM bus.

Parameters:
- TRCD, 3, minimum ck edges from ACTIVATE to READ/WRITE on the same bank (≥1).
- FIFO_DEPTH, 8, transaction FIFO entries (power of 2, ≥2).

Ports:
- ck  in  1  clock; all sampling on posedge.
- reset  in  1  asynchronous, active-high reset.
- cke  in  1  clock enable from controller.
- addr  in  13  DRAM address bus; A10 is the precharge/auto-precharge flag.
- ba  in  2  bank address.
- cs_n, ras_n, cas_n, we_n  in  1 each  active-low command strobes.
- txn_valid  out  1  FIFO head valid.
- txn_ready  in  1  consumer accepts head.
- txn_cmd  out  2  0 = ACT, 1 = RD, 2 = WR, 3 = PRE.
- txn_bank  out  2  bank of record.
- txn_row  out  13  row of record.
- txn_col  out  10  column of record.
- txn_ap  out  1  auto-precharge (RD/WR) or all-bank (PRE).
- err_valid  out  1  one-cycle error pulse.
- err_code  out  3  error code, valid with err_valid.
- overflow  out  1  sticky FIFO-overflow flag.
- open_banks  out  4  bit b set = bank b open.

Behaviour:
- Reset (async, active-high) values:
  - all outputs 0; open table cleared; tRCD counters = TRCD.
  - FIFO empty; cke_prev = 0.
- Command is decoded at a posedge only when reset = 0, cke = 1 and cke_prev = 1. cke_prev <= cke every edge.
- Encoding of {cs_n, ras_n, cas_n, we_n}:
  - 0011 ACT, 0101 RD, 0100 WR, 0010 PRE.
  - 0111 NOP; anything else is ignored with no record and no error.
- ACT:
  - row[ba] <= addr; open[ba] <= 1; cnt[ba] <= 1.
  - push {ACT, ba, addr, col 0, ap 0}.
  - If bank already open: err 2 (ACT_OPEN); table still updated.
- RD/WR:
  - If bank closed: err 1 (CLOSED), no push.
  - Otherwise push {cmd, ba, row[ba], addr[9:0], addr[10]}.
  - If cnt[ba] < TRCD: err 3 (TRCD); record still pushed.
  - If addr[10] = 1, open[ba] <= 0 at the same edge.
- PRE:
  - addr[10] = 1: all banks closed; push {PRE, 0, 0, 0, 1}.
  - addr[10] = 0: open[ba] <= 0; push {PRE, ba, 0, 0, 0}.
  - PRE to an already-closed bank is legal: no error.
- tRCD counters: increment by 1 every edge, saturating at TRCD. Loaded to 1 on ACT.
  - Net rule: ACT at edge N makes RD/WR legal at edge N+TRCD or later.
- Latency: command at edge N gives txn_valid / err_valid / open_banks updated after edge N.
  - err_valid lasts exactly one cycle.
- FIFO:
  - First-word fall-through; txn_valid = !empty; head fields are registered.
  - Pop when txn_valid && txn_ready.
  - Push while full is accepted only if a pop happens in the same cycle.
  - Otherwise the record is dropped and overflow is set; it stays set until reset.
  - An overflow drop also pulses err 4 (OVF), unless a protocol error fires in the same cycle. The protocol error code wins, but overflow is still set.
- Reset mid-burst or mid-handshake: FIFO flushed and txn_valid drops immediately (async); the consumer discards any in-flight handshake.
- cke deassertion: no decode for that edge and the next edge after cke returns. tRCD counters keep counting.

Decomposition:
- Shared package ddr2_pkg holds:
  - command encodings CMD_ACT/RD/WR/PRE/NOP;
  - txn_cmd_e enum;
  - ddr2_txn_t packed struct {cmd, bank, row, col, ap};
  - err_code_e enum (NONE = 0, CLOSED = 1, ACT_OPEN = 2, TRCD = 3, OVF = 4).
- The monitor reuses the package encodings.
- Sub-module ddr2_txn_fifo: parameterised sync FIFO of ddr2_txn_t with full/empty, simultaneous push/pop, and async reset.

Test Plan:
- Open and read:
  - ACT bank 2 row 0x1A5 at edge 10, RD bank 2 col 0x040 at edge 13 (TRCD = 3).
  - Expect records ACT{2, 0x1A5} then RD{2, 0x1A5, 0x040, ap 0}, no err, open_banks = 0100.
- tRCD violation:
  - ACT bank 0 at edge 5, WR bank 0 at edge 6.
  - Expect err_valid with code 3 after edge 6, WR record still present, row correct.
- Closed-bank access and PRE-all:
  - ACT banks 0 and 3, PRE with A10 = 1, then RD bank 3.
  - Expect PRE{ap 1}, open_banks = 0000, err 1, no RD record.
- Auto-precharge:
  - RD bank 1 with A10 = 1 after a legal ACT.
  - Expect txn_ap = 1 and open_banks[1] cleared after that edge. ACT bank 1 again gives no err 2.
- Overflow:
  - Hold txn_ready = 0, issue 9 ACT/PRE records (FIFO_DEPTH = 8).
  - Expect 8 records retained, err 4 on the 9th, overflow = 1 persisting.
  - A push plus pop in the same cycle while full keeps the count at 8 with no error.
- Async reset / cke gating:
  - Assert reset between edges with 3 records queued: txn_valid = 0 immediately, overflow cleared.
  - ACT with cke rising on the same edge is ignored; ACT one edge later is recorded.
